// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready handshake,
// synchronous flush, control zeroing on bubbles and optional two-entry skid buffer.
//
// Optional feature macro: PIPE_SKID_EN (skid register + FULL state; registered in_ready_o).
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   flush_i      synchronous flush, empties the stage and drops that cycle's input
//   in_valid_i   upstream entry valid
//   in_ready_o   stage accepts an entry this cycle (forced high during flush)
//   in_data_i    datapath payload in  [DATA_W]
//   in_ctrl_i    control payload in   [CTRL_W]
//   out_valid_o  output entry valid
//   out_ready_i  downstream consumes output entry this cycle
//   out_data_o   datapath payload out [DATA_W], held while invalid
//   out_ctrl_o   control payload out  [CTRL_W], zero while invalid
//   count_o      entries held (0..2 with skid, 0..1 without)
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        count_o
);
    typedef enum logic [1:0] {EMPTY = 2'd0, MAIN = 2'd1, FULL = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic              in_fire, out_fire;

    assign in_fire  = in_valid_i & in_ready_o & ~flush_i;
    assign out_fire = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state_q <= EMPTY;
        else       state_q <= state_d;

    always_comb begin
        state_d = state_q;
        if (flush_i)
            state_d = EMPTY;
        else
            case (state_q)
                EMPTY:   state_d = in_fire ? MAIN : EMPTY;
`ifdef PIPE_SKID_EN
                MAIN:    state_d = (out_fire && !in_fire) ? EMPTY :
                                   (in_fire && !out_fire) ? FULL : MAIN;
                FULL:    state_d = out_fire ? MAIN : FULL;
`else
                // Without skid an input in MAIN implies out_ready_i, so FULL is unreachable.
                MAIN:    state_d = (out_fire && !in_fire) ? EMPTY : MAIN;
`endif
                default: state_d = EMPTY;
            endcase
    end

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic              rdy_q;

    // Ready is computed from the next state so it is a pure register output,
    // breaking any combinational path from out_ready_i.
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            rdy_q       <= 1'b1;
        end else begin
            rdy_q <= (state_d != FULL);
            if (state_q == MAIN && in_fire && !out_fire) begin
                skid_data_q <= in_data_i;
                skid_ctrl_q <= in_ctrl_i;
            end
        end
`endif

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else if (in_fire && (state_q == EMPTY || out_fire)) begin
            main_data_q <= in_data_i;
            main_ctrl_q <= in_ctrl_i;
        end
`ifdef PIPE_SKID_EN
        else if (state_q == FULL && out_fire) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
        end
`endif

    always_comb begin
        out_valid_o = (state_q != EMPTY);
        out_data_o  = main_data_q;
        out_ctrl_o  = out_valid_o ? main_ctrl_q : '0;
`ifdef PIPE_SKID_EN
        in_ready_o  = rdy_q | flush_i;
        count_o     = state_q;
`else
        in_ready_o  = (state_q == EMPTY) | out_ready_i | flush_i;
        count_o     = {1'b0, state_q == MAIN};
`endif
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg (works with or without PIPE_SKID_EN).
module tb_pipe_stage_reg;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    count;

    int checks = 0;
    int failures = 0;
    logic [CW+DW-1:0] sb[$];

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_ctrl_o(out_ctrl),
        .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        flush     = f;
    endtask

    // One clock cycle: check outputs mid-cycle against the model, update the model, advance.
    task automatic cyc();
        logic             exp_rdy;
        logic [CW+DW-1:0] e;
        @(negedge clk);
`ifdef PIPE_SKID_EN
        exp_rdy = flush || sb.size() < 2;
`else
        exp_rdy = flush || sb.size() == 0 || out_ready;
`endif
        check("in_ready", in_ready, exp_rdy);
        check("count", count, sb.size());
        check("out_valid", out_valid, sb.size() != 0);
        if (!out_valid) check("ctrl_bubble", out_ctrl, 0);
        if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            check("out_data", out_data, e[DW-1:0]);
            check("out_ctrl", out_ctrl, e[CW+DW-1:DW]);
        end
        if (flush) sb.delete();
        else if (in_valid && exp_rdy) sb.push_back({in_ctrl, in_data});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_ctrl", out_ctrl, 0);
        check("rst_data", out_data, 0);
        check("rst_count", count, 0);
        check("rst_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stream three entries at full throughput
        drive(1, 32'h11, 8'h05, 1, 0); cyc();
        drive(1, 32'h22, 8'h05, 1, 0); cyc();
        drive(1, 32'h33, 8'h05, 1, 0); cyc();
        drive(0, 32'h0, 8'h00, 1, 0); repeat (2) cyc();

        // Back-pressure: 0xAA held, 0xBB offered while stalled, then release
        drive(1, 32'hAA, 8'h01, 0, 0); cyc();
        drive(1, 32'hBB, 8'h02, 0, 0); repeat (2) cyc();
        drive(1, 32'hBB, 8'h02, 1, 0); cyc();
        drive(0, 32'h0, 8'h00, 1, 0); repeat (3) cyc();

        // Fill (FULL with skid), then flush while 0xCC is offered
        drive(1, 32'hDD, 8'h03, 0, 0); cyc();
        drive(1, 32'hDE, 8'h04, 0, 0); cyc();
        drive(1, 32'hCC, 8'h0C, 0, 1); cyc();
        drive(0, 32'h0, 8'h00, 0, 0); cyc();
        @(negedge clk);
        check("flush_count", count, 0);
        check("flush_ctrl", out_ctrl, 0);
        @(posedge clk); #1;
        drive(0, 32'h0, 8'h00, 1, 0); repeat (3) cyc();

        // Asynchronous reset between edges while holding ctrl 0xFF
        drive(1, 32'h77, 8'hFF, 0, 0); cyc();
        drive(0, 32'h0, 8'h00, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_ctrl", out_ctrl, 0);
        check("arst_data", out_data, 0);
        check("arst_count", count, 0);
        check("arst_ready", in_ready, 1);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        cyc();

        // Randomised valid/ready/flush traffic
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 8'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
            cyc();
        end
        drive(0, 32'h0, 8'h00, 1, 0);
        repeat (4) cyc();
        check("drain_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
